keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 1000: clock cycles each column stays driven while scanning; legal minimum 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required to accept a press or a release; legal minimum 2.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 row_in  input  4  raw keypad row sense, active-high, asynchronous to clk.
REQ-007 col_drive  output  4  one-hot active-high column drive to the keypad.
REQ-008 rows  output  4  one-hot row of the last accepted key, for the keypad decoder.
REQ-009 cols  output  4  one-hot column of the last accepted key, for the keypad decoder.
REQ-010 key_valid  output  1  one-cycle pulse when a new debounced press is accepted.
REQ-011 pressed  output  1  high while the accepted key is held or its release is being debounced.

Function
REQ-012 row_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value, row_s.
REQ-013 The FSM SHALL have four states: SCAN, DEBOUNCE, HELD and RELEASE.
REQ-014 SCAN behaviour:
- scan_cnt counts 0..SCAN_CYCLES-1.
- At terminal count, col_drive rotates 0001->0010->0100->1000->0001 and scan_cnt clears.
REQ-015 Press detection in SCAN:
- Only when scan_cnt >= 2 (synchronizer settle) and row_s is exactly one-hot.
- Then latch row_s as cand_row and col_drive as cand_col, clear deb_cnt, enter DEBOUNCE.
- Rotation stops; col_drive holds.
REQ-016 SCAN SHALL ignore row_s values that are zero or multi-hot.
REQ-017 DEBOUNCE behaviour:
- Each cycle row_s == cand_row increments deb_cnt.
- Any mismatch: return to SCAN, rotate col_drive to the next column, clear scan_cnt, no pulse.
REQ-018 DEBOUNCE accept:
- When deb_cnt == DEBOUNCE_CYCLES-1 and row_s matches, the next edge enters HELD.
- On that edge: load rows<=cand_row and cols<=cand_col, key_valid<=1 for exactly one cycle, pressed<=1.
- key_valid therefore rises exactly DEBOUNCE_CYCLES cycles after the edge that entered DEBOUNCE.
REQ-019 HELD behaviour:
- col_drive is held.
- Stay while the cand_row bit of row_s is 1.
- Other row bits are ignored; no additional pulses (no rollover, no auto-repeat).
- When the cand_row bit reads 0: clear deb_cnt, enter RELEASE.
REQ-020 RELEASE behaviour:
- deb_cnt increments each cycle the cand_row bit is 0.
- If the bit reads 1: return to HELD, no key_valid.
- At deb_cnt == DEBOUNCE_CYCLES-1 with the bit still 0: next edge enters SCAN, pressed<=0, col_drive rotates to the next column, scan_cnt clears.
REQ-021 rows and cols SHALL hold their value until the next accepted press; they are never cleared by release.
REQ-022 key_valid SHALL never be high in two consecutive cycles.
REQ-023 Counter widths:
- scan_cnt is $clog2(SCAN_CYCLES) bits; deb_cnt is $clog2(DEBOUNCE_CYCLES) bits.
- Neither counter wraps past its terminal count.

Reset
REQ-024 Reset SHALL drive, on the next edge:
- state=SCAN, col_drive=4'b0001.
- rows=4'b0000, cols=4'b0000.
- key_valid=0, pressed=0.
- scan_cnt=0, deb_cnt=0, synchronizer flops=0.
REQ-025 Reset asserted in any state, including mid-DEBOUNCE or mid-RELEASE, SHALL take priority, abort the operation and emit no key_valid.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset for 2 cycles, then idle with row_in=0 -> col_drive=0001, rows=cols=0, key_valid=0, pressed=0; col_drive then cycles 0010, 0100, 1000, 0001 every 4 cycles.
REQ-027 Key 5 held for 40 cycles (row_in=0010 whenever col_drive=0010) -> exactly one key_valid, 8 cycles after entering DEBOUNCE; rows=0010, cols=0010, pressed=1; col_drive stays 0010 while held.
REQ-028 Bounce, row_in=0001 under col_drive=0001 for 3 cycles only -> no key_valid; scanning resumes with col_drive=0010; rows and cols unchanged.
REQ-029 Release glitch after key 5 accepted, row_in drops for 4 cycles then returns for 1 cycle -> returns to HELD, pressed stays 1, no second pulse; a full 8-cycle release then gives pressed=0 and col_drive=0100.
REQ-030 Second key while key 5 held (row_in=0110), followed by release then a press of key D (row_in=1000 under col_drive=1000) -> no pulse during the hold; one pulse on key D with rows=1000, cols=1000.
REQ-031 Reset asserted at deb_cnt=5 during DEBOUNCE -> no key_valid; all outputs at reset values on the next edge.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates column drive, debounces a single-key press
// and release, and reports the accepted key as one-hot row/column.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic       pressed
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE    = SW'(2);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t        state, state_n;
  logic [3:0]    sync1, row_s;
  logic [SW-1:0] scan_cnt, scan_cnt_n;
  logic [DW-1:0] deb_cnt, deb_cnt_n;
  logic [3:0]    cand_row, cand_row_n;
  logic [3:0]    cand_col, cand_col_n;
  logic [3:0]    col_n, rows_n, cols_n, col_rot;
  logic          kv_n, pressed_n;
  logic          onehot, match, hold_bit;

  assign onehot   = (row_s != 4'd0) &&
                    ((row_s & (row_s - 4'd1)) == 4'd0);
  assign match    = row_s == cand_row;
  assign hold_bit = |(row_s & cand_row);
  assign col_rot  = {col_drive[2:0], col_drive[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'd0;
      row_s <= 4'd0;
    end else begin
      sync1 <= row_in;
      row_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      cand_row  <= 4'd0;
      cand_col  <= 4'd0;
      col_drive <= 4'b0001;
      rows      <= 4'd0;
      cols      <= 4'd0;
      key_valid <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      state     <= state_n;
      scan_cnt  <= scan_cnt_n;
      deb_cnt   <= deb_cnt_n;
      cand_row  <= cand_row_n;
      cand_col  <= cand_col_n;
      col_drive <= col_n;
      rows      <= rows_n;
      cols      <= cols_n;
      key_valid <= kv_n;
      pressed   <= pressed_n;
    end
  end

  always_comb begin
    state_n    = state;
    scan_cnt_n = scan_cnt;
    deb_cnt_n  = deb_cnt;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    col_n      = col_drive;
    rows_n     = rows;
    cols_n     = cols;
    kv_n       = 1'b0;
    pressed_n  = pressed;
    unique case (state)
      SCAN: begin
        // first two counts let the synchronizer flush the old column
        if (scan_cnt >= SETTLE && onehot) begin
          cand_row_n = row_s;
          cand_col_n = col_drive;
          deb_cnt_n  = '0;
          state_n    = DEBOUNCE;
        end else if (scan_cnt == SCAN_LAST) begin
          col_n      = col_rot;
          scan_cnt_n = '0;
        end else begin
          scan_cnt_n = scan_cnt + SCAN_ONE;
        end
      end
      DEBOUNCE: begin
        if (!match) begin
          state_n    = SCAN;
          col_n      = col_rot;
          scan_cnt_n = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_n   = HELD;
          rows_n    = cand_row;
          cols_n    = cand_col;
          kv_n      = 1'b1;
          pressed_n = 1'b1;
        end else begin
          deb_cnt_n = deb_cnt + DEB_ONE;
        end
      end
      HELD: begin
        if (!hold_bit) begin
          deb_cnt_n = '0;
          state_n   = RELEASE;
        end
      end
      RELEASE: begin
        if (hold_bit) begin
          state_n = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_n    = SCAN;
          pressed_n  = 1'b0;
          col_n      = col_rot;
          scan_cnt_n = '0;
        end else begin
          deb_cnt_n = deb_cnt + DEB_ONE;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
// A keypad model returns key_row whenever the driven column hits key_col.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_drive, rows, cols;
  logic       key_valid, pressed;

  logic [3:0] key_row = 4'd0;
  logic [3:0] key_col = 4'd0;

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0;
  int consec = 0;
  logic kv_prev = 1'b0;
  bit ok;

  assign row_in = ((col_drive & key_col) != 4'd0) ? key_row : 4'd0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .col_drive(col_drive),
    .rows(rows),
    .cols(cols),
    .key_valid(key_valid),
    .pressed(pressed)
  );

  always @(posedge clk) begin
    if (key_valid === 1'b1) begin
      kv_cnt++;
      if (kv_prev) consec++;
    end
    kv_prev = (key_valid === 1'b1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_kv(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (key_valid === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rel(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (pressed === 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [3:0] v, input int budget,
                          output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (col_drive === v) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    step(2);
    chk("rst_col", col_drive, 4'b0001);
    chk("rst_rows", rows, 4'b0000);
    chk("rst_cols", cols, 4'b0000);
    chk("rst_kv", key_valid, 1'b0);
    chk("rst_pressed", pressed, 1'b0);
    reset = 1'b0;

    step(3);
    chk("idle_col0", col_drive, 4'b0001);
    step(1);
    chk("idle_col1", col_drive, 4'b0010);
    step(4);
    chk("idle_col2", col_drive, 4'b0100);
    step(4);
    chk("idle_col3", col_drive, 4'b1000);
    step(4);
    chk("idle_col4", col_drive, 4'b0001);
    chk("idle_kvcnt", kv_cnt, 0);

    key_row = 4'b0010;
    key_col = 4'b0010;
    step(14);
    chk("k5_early_kv", key_valid, 1'b0);
    chk("k5_col_hold", col_drive, 4'b0010);
    step(1);
    chk("k5_kv", key_valid, 1'b1);
    chk("k5_rows", rows, 4'b0010);
    chk("k5_cols", cols, 4'b0010);
    chk("k5_pressed", pressed, 1'b1);
    step(1);
    chk("k5_kv_drop", key_valid, 1'b0);
    step(24);
    chk("k5_held_col", col_drive, 4'b0010);
    chk("k5_held_pr", pressed, 1'b1);
    chk("k5_kvcnt", kv_cnt, 1);

    key_col = 4'b0000;
    step(4);
    key_col = 4'b0010;
    step(1);
    key_col = 4'b0000;
    chk("gl_pressed", pressed, 1'b1);
    step(10);
    chk("gl_still_pr", pressed, 1'b1);
    chk("gl_kvcnt", kv_cnt, 1);
    step(1);
    chk("rel_pressed", pressed, 1'b0);
    chk("rel_col", col_drive, 4'b0100);
    chk("rel_rows", rows, 4'b0010);

    key_row = 4'b0001;
    key_col = 4'b0001;
    step(8);
    chk("bn_col", col_drive, 4'b0001);
    step(3);
    key_col = 4'b0000;
    step(2);
    chk("bn_col_hold", col_drive, 4'b0001);
    step(1);
    chk("bn_col_next", col_drive, 4'b0010);
    chk("bn_kvcnt", kv_cnt, 1);
    chk("bn_rows", rows, 4'b0010);
    chk("bn_cols", cols, 4'b0010);
    chk("bn_pressed", pressed, 1'b0);

    key_row = 4'b0010;
    key_col = 4'b0010;
    wait_kv(40, ok);
    chk("k5b_seen", ok, 1'b1);
    chk("k5b_rows", rows, 4'b0010);
    key_row = 4'b0110;
    step(20);
    chk("two_kvcnt", kv_cnt, 2);
    chk("two_pressed", pressed, 1'b1);
    chk("two_col", col_drive, 4'b0010);
    chk("two_rows", rows, 4'b0010);
    key_row = 4'b0000;
    wait_rel(40, ok);
    chk("two_rel", ok, 1'b1);
    chk("two_rel_col", col_drive, 4'b0100);

    key_row = 4'b1000;
    key_col = 4'b1000;
    wait_kv(60, ok);
    chk("kd_seen", ok, 1'b1);
    chk("kd_rows", rows, 4'b1000);
    chk("kd_cols", cols, 4'b1000);
    step(2);
    chk("kd_kvcnt", kv_cnt, 3);
    chk("kd_pressed", pressed, 1'b1);

    key_row = 4'b0000;
    key_col = 4'b0000;
    wait_rel(40, ok);
    chk("kd_rel", ok, 1'b1);
    key_row = 4'b0010;
    key_col = 4'b0010;
    wait_col(4'b0010, 20, ok);
    chk("ab_col", ok, 1'b1);
    step(8);
    chk("ab_col_hold", col_drive, 4'b0010);
    chk("ab_pre_kv", kv_cnt, 3);
    reset = 1'b1;
    step(1);
    chk("ab_col", col_drive, 4'b0001);
    chk("ab_rows", rows, 4'b0000);
    chk("ab_cols", cols, 4'b0000);
    chk("ab_kv", key_valid, 1'b0);
    chk("ab_pressed", pressed, 1'b0);
    reset = 1'b0;
    key_row = 4'b0000;
    key_col = 4'b0000;
    step(12);
    chk("ab_kvcnt", kv_cnt, 3);
    chk("kv_consec", consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
